// File: rtl/dcnn_dma_pkg.sv
// Shared types and constants for the DMA arbiter slice.
//   dma_state_e      : arbiter sequencer states
//   DMA_ADDR_W/DATA_W: default DMA address / word widths
//   RW_READ/RW_WRITE : direction encoding on rw_i and dma_rw_o
package dcnn_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } dma_state_e;

    localparam int DMA_ADDR_W = 16;
    localparam int DMA_DATA_W = 16;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: selects the first active request at or after the
// pointer, wrapping around.
//   req_i   : request vector
//   ptr_i   : round-robin start index
//   pick_o  : one-hot selected requester (zero when no request)
//   valid_o : any request active
module rr_picker #(
    parameter int NREQ  = 3,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  pick_o,
    output logic             valid_o
);

    logic             found;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        pick_o = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr + k never exceeds 2*NREQ-2, so one subtraction wraps it
            sum = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NREQ)) begin
                sum = sum - (PTR_W+1)'(NREQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/dma_arbiter.sv
// Round-robin arbiter/sequencer sharing one DMA memory port between NREQ
// requesters. One DMA access per grant; locked requesters may chain
// accesses without returning to IDLE.
//   clk, reset         : clock, synchronous active-high reset
//   req_i/lock_i/rw_i  : per-requester request, burst lock, direction
//   addr_i/wdata_i     : packed per-requester address / write word
//   gnt_o/done_o       : one-hot grant, one-hot completion pulse
//   rdata_o            : last read result, held
//   busy_o             : sequencer not idle
//   dma_*_o/dma_rdata_i: DMA port
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | no access in flight, arbitrate
// ST_ISSUE | one cycle, dma_en high
// ST_WAIT  | DMA_LAT-1 cycles of latency (skipped if DMA_LAT=1)
// ST_DONE  | one cycle, done pulse to granted requester
module dma_arbiter
    import dcnn_dma_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = DMA_ADDR_W,
    parameter int DATA_W  = DMA_DATA_W,
    parameter int WORDS   = 25,
    parameter int DMA_LAT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_i,
    input  logic [NREQ-1:0]           lock_i,
    input  logic [NREQ-1:0]           rw_i,
    input  logic [NREQ*ADDR_W-1:0]    addr_i,
    input  logic [NREQ*DATA_W-1:0]    wdata_i,
    output logic [NREQ-1:0]           gnt_o,
    output logic [NREQ-1:0]           done_o,
    output logic [WORDS*DATA_W-1:0]   rdata_o,
    output logic                      busy_o,
    output logic                      dma_en_o,
    output logic                      dma_rw_o,
    output logic [ADDR_W-1:0]         dma_addr_o,
    output logic [DATA_W-1:0]         dma_wdata_o,
    input  logic [WORDS*DATA_W-1:0]   dma_rdata_i
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (DMA_LAT > 2) ? $clog2(DMA_LAT - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((DMA_LAT > 1) ? DMA_LAT - 2 : 0);

    dma_state_e                state_q, state_d;
    logic [NREQ-1:0]           gnt_q, gnt_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      dma_rw_q;
    logic [ADDR_W-1:0]         dma_addr_q;
    logic [DATA_W-1:0]         dma_wdata_q;
    logic [WORDS*DATA_W-1:0]   rdata_q;

    logic [NREQ-1:0]           pick;
    logic                      pick_valid;
    logic [PTR_W-1:0]          gnt_idx, ptr_next;
    logic                      load;
    logic                      capture;
    logic                      sel_rw;
    logic [ADDR_W-1:0]         sel_addr;
    logic [DATA_W-1:0]         sel_wdata;

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .pick_o  (pick),
        .valid_o (pick_valid)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) gnt_idx = PTR_W'(i);
        end
    end

    assign ptr_next = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

    // Request fields of the requester that will own the ISSUE cycle
    always_comb begin
        sel_rw    = RW_WRITE;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_d[i]) begin
                sel_rw    = rw_i[i];
                sel_addr  = addr_i[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_ISSUE;
                    gnt_d   = pick;
                    load    = 1'b1;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_INIT;
                state_d = (DMA_LAT == 1) ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Burst: the same requester keeps the port, pointer untouched
                if (|(gnt_q & req_i & lock_i)) begin
                    state_d = ST_ISSUE;
                    load    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    ptr_d   = ptr_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data is sampled at the end of the last latency cycle
    assign capture = (dma_rw_q == RW_READ) &&
                     ((DMA_LAT == 1) ? (state_q == ST_ISSUE)
                                     : (state_q == ST_WAIT && cnt_q == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            dma_rw_q    <= 1'b0;
            dma_addr_q  <= '0;
            dma_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            if (load) begin
                dma_rw_q    <= sel_rw;
                dma_addr_q  <= sel_addr;
                dma_wdata_q <= sel_wdata;
            end
            if (capture) begin
                rdata_q <= dma_rdata_i;
            end
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = (state_q == ST_DONE) ? gnt_q : '0;
    assign busy_o      = (state_q != ST_IDLE);
    assign dma_en_o    = (state_q == ST_ISSUE);
    assign dma_rw_o    = dma_rw_q;
    assign dma_addr_o  = dma_addr_q;
    assign dma_wdata_o = dma_wdata_q;
    assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// Self-checking bench for dma_arbiter (NREQ=3, DMA_LAT=2). Expected DMA
// issues and completions are queued when stimulus is applied and checked
// by a monitor as the DUT produces them.
module tb_dma_arbiter;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int WORDS  = 25;
    localparam int RDW    = WORDS * DATA_W;

    typedef logic [RDW-1:0] wide_t;

    typedef struct {
        int          cyc;
        int          g;
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wdata;
    } en_t;

    typedef struct {
        int    cyc;
        int    g;
        wide_t rdata;
    } dn_t;

    logic                    clk;
    logic                    reset;
    logic [NREQ-1:0]         req, lock, rw;
    logic [NREQ*ADDR_W-1:0]  addr;
    logic [NREQ*DATA_W-1:0]  wdata;
    logic [NREQ-1:0]         gnt, done;
    wide_t                   rdata;
    logic                    busy, dma_en, dma_rw;
    logic [ADDR_W-1:0]       dma_addr;
    logic [DATA_W-1:0]       dma_wdata;
    wide_t                   dma_rdata;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    c0;
    wide_t exp_rdata;
    en_t   exp_en[$];
    dn_t   exp_dn[$];
    en_t   en_e;
    dn_t   dn_e;

    dma_arbiter #(
        .NREQ    (NREQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .WORDS   (WORDS),
        .DMA_LAT (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req),
        .lock_i      (lock),
        .rw_i        (rw),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .gnt_o       (gnt),
        .done_o      (done),
        .rdata_o     (rdata),
        .busy_o      (busy),
        .dma_en_o    (dma_en),
        .dma_rw_o    (dma_rw),
        .dma_addr_o  (dma_addr),
        .dma_wdata_o (dma_wdata),
        .dma_rdata_i (dma_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input wide_t obs, input wide_t expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Read data presented in cycle c; changes every cycle so capture timing matters
    function automatic wide_t pat(input int c);
        wide_t r;
        r = '0;
        for (int w = 0; w < WORDS; w++) r[w*DATA_W +: DATA_W] = 16'(c * 32 + w);
        return r;
    endfunction

    task automatic set_req(input int i, input logic r, input logic [15:0] a, input logic [15:0] d);
        rw[i]                  = r;
        addr[i*ADDR_W +: ADDR_W] = a;
        wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic push_en(input int c, input int g, input logic r, input logic [15:0] a, input logic [15:0] d);
        en_t e;
        e.cyc = c; e.g = g; e.rw = r; e.addr = a; e.wdata = d;
        exp_en.push_back(e);
        if (r) exp_rdata = pat(c + 1);
    endtask

    task automatic push_dn(input int c, input int g);
        dn_t e;
        e.cyc = c; e.g = g; e.rdata = exp_rdata;
        exp_dn.push_back(e);
    endtask

    task automatic push_acc(input int ci, input int g, input logic r, input logic [15:0] a, input logic [15:0] d);
        push_en(ci, g, r, a, d);
        push_dn(ci + 2, g);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain_chk(input string tag);
        chk({tag, "_en_left"}, wide_t'(exp_en.size()), '0);
        chk({tag, "_dn_left"}, wide_t'(exp_dn.size()), '0);
        exp_en.delete();
        exp_dn.delete();
    endtask

    // Monitor: outputs are stable at the falling edge
    always @(negedge clk) begin
        if (dma_en) begin
            if (exp_en.size() == 0) begin
                chk("unexp_en", wide_t'(dma_en), '0);
            end else begin
                en_e = exp_en.pop_front();
                chk("en_cyc",   wide_t'(cyc),       wide_t'(en_e.cyc));
                chk("en_gnt",   wide_t'(gnt),       wide_t'(1) << en_e.g);
                chk("en_rw",    wide_t'(dma_rw),    wide_t'(en_e.rw));
                chk("en_addr",  wide_t'(dma_addr),  wide_t'(en_e.addr));
                chk("en_wdata", wide_t'(dma_wdata), wide_t'(en_e.wdata));
                chk("en_busy",  wide_t'(busy),      wide_t'(1));
            end
        end
        if (done != '0) begin
            if (exp_dn.size() == 0) begin
                chk("unexp_done", wide_t'(done), '0);
            end else begin
                dn_e = exp_dn.pop_front();
                chk("dn_cyc",   wide_t'(cyc),  wide_t'(dn_e.cyc));
                chk("dn_vec",   wide_t'(done), wide_t'(1) << dn_e.g);
                chk("dn_rdata", rdata,         dn_e.rdata);
            end
        end
        dma_rdata = pat(cyc);
    end

    initial begin
        reset = 1'b1;
        req = '0; lock = '0; rw = '0; addr = '0; wdata = '0;
        dma_rdata = '0;
        exp_rdata = '0;
        step(3);
        chk("rst_gnt",   wide_t'(gnt),       '0);
        chk("rst_done",  wide_t'(done),      '0);
        chk("rst_busy",  wide_t'(busy),      '0);
        chk("rst_en",    wide_t'(dma_en),    '0);
        chk("rst_rw",    wide_t'(dma_rw),    '0);
        chk("rst_addr",  wide_t'(dma_addr),  '0);
        chk("rst_wdata", wide_t'(dma_wdata), '0);
        chk("rst_rdata", rdata,              '0);
        reset = 1'b0;
        step(1);

        // All three requesting: served 0,1,2 from pointer 0
        c0 = cyc;
        set_req(0, 1'b1, 16'd10, 16'h00A0);
        set_req(1, 1'b0, 16'd11, 16'h00B1);
        set_req(2, 1'b1, 16'd12, 16'h00C2);
        req = 3'b111;
        push_acc(c0 + 1, 0, 1'b1, 16'd10, 16'h00A0);
        push_acc(c0 + 5, 1, 1'b0, 16'd11, 16'h00B1);
        push_acc(c0 + 9, 2, 1'b1, 16'd12, 16'h00C2);
        step(1); req[0] = 1'b0;
        step(4); req[1] = 1'b0;
        step(4); req[2] = 1'b0;
        step(4);
        chk("all_idle", wide_t'(busy), '0);
        drain_chk("all");

        // Single read from requester 0; pointer now 0
        c0 = cyc;
        set_req(0, 1'b1, 16'd100, 16'h00A0);
        req = 3'b001;
        push_acc(c0 + 1, 0, 1'b1, 16'd100, 16'h00A0);
        step(1); req = '0;
        step(4);
        drain_chk("rd");

        // Write from requester 1: rdata keeps the previous read
        c0 = cyc;
        set_req(1, 1'b0, 16'd50, 16'h1234);
        req = 3'b010;
        push_acc(c0 + 1, 1, 1'b0, 16'd50, 16'h1234);
        step(1); req = '0;
        step(4);
        chk("wr_rdata_held", rdata, exp_rdata);
        drain_chk("wr");

        // Locked burst on requester 2 (pointer 2) with requester 0 waiting;
        // after the last DONE one IDLE cycle precedes requester 0's issue
        c0 = cyc;
        set_req(2, 1'b1, 16'd200, 16'h0002);
        set_req(0, 1'b0, 16'd300, 16'h5A5A);
        req  = 3'b101;
        lock = 3'b100;
        push_acc(c0 + 1,  2, 1'b1, 16'd200, 16'h0002);
        push_acc(c0 + 4,  2, 1'b1, 16'd201, 16'h0002);
        push_acc(c0 + 7,  2, 1'b1, 16'd202, 16'h0002);
        push_acc(c0 + 11, 0, 1'b0, 16'd300, 16'h5A5A);
        step(3); addr[2*ADDR_W +: ADDR_W] = 16'd201;
        chk("burst_gnt_held", wide_t'(gnt), wide_t'(3'b100));
        step(3); addr[2*ADDR_W +: ADDR_W] = 16'd202;
        step(3); lock = '0; req[2] = 1'b0;
        step(2); req[0] = 1'b0;
        step(3);
        drain_chk("burst");

        // Fairness: 0 and 1 held continuously from pointer 1 -> 1,0,1,0
        c0 = cyc;
        set_req(0, 1'b0, 16'h0040, 16'h0400);
        set_req(1, 1'b0, 16'h0041, 16'h0411);
        req = 3'b011;
        push_acc(c0 + 1,  1, 1'b0, 16'h0041, 16'h0411);
        push_acc(c0 + 5,  0, 1'b0, 16'h0040, 16'h0400);
        push_acc(c0 + 9,  1, 1'b0, 16'h0041, 16'h0411);
        push_acc(c0 + 13, 0, 1'b0, 16'h0040, 16'h0400);
        step(13); req = '0;
        step(4);
        drain_chk("fair");

        // Reset during WAIT abandons the access without a done
        c0 = cyc;
        set_req(2, 1'b1, 16'h0077, 16'h0777);
        req = 3'b100;
        push_en(c0 + 1, 2, 1'b1, 16'h0077, 16'h0777);
        step(1); req = '0;
        step(1); reset = 1'b1;
        step(1);
        chk("rw_gnt",   wide_t'(gnt),       '0);
        chk("rw_done",  wide_t'(done),      '0);
        chk("rw_busy",  wide_t'(busy),      '0);
        chk("rw_en",    wide_t'(dma_en),    '0);
        chk("rw_rw",    wide_t'(dma_rw),    '0);
        chk("rw_addr",  wide_t'(dma_addr),  '0);
        chk("rw_wdata", wide_t'(dma_wdata), '0);
        chk("rw_rdata", rdata,              '0);
        exp_rdata = '0;
        reset = 1'b0;
        c0 = cyc;
        set_req(1, 1'b1, 16'h0066, 16'h0666);
        req = 3'b010;
        push_acc(c0 + 1, 1, 1'b1, 16'h0066, 16'h0666);
        step(1); req = '0;
        step(5);
        drain_chk("rst_wait");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
